// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: response owner, in-flight tag,
// and the fetch-kill helper used by the response tracker.
package mem_arb_pkg;

  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } mem_tag_t;

  // A branch flush kills any fetch response still travelling through the tag pipe.
  function automatic mem_tag_t flush_mask(input mem_tag_t tag, input logic flush);
    flush_mask = tag;
    if (flush && (tag.owner == OWN_I)) begin
      flush_mask.valid = 1'b0;
    end
  endfunction

endpackage

// File: rtl/resp_tracker.sv
// Fixed-latency tag pipeline recording who owns each outstanding read; the tail
// stage lines up with the memory's read data.
module resp_tracker
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  owner_e   push_owner,
  input  logic     i_flush,
  output mem_tag_t tail_c
);

  mem_tag_t stage_q [DEPTH];
  mem_tag_t push_tag;

  assign push_tag = '{valid: push, owner: push_owner};

  // Shift every cycle; flush masking is applied on the way into each stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '{valid: 1'b0, owner: OWN_I};
      end
    end else begin
      stage_q[0] <= flush_mask(push_tag, i_flush);
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= flush_mask(stage_q[i-1], i_flush);
      end
    end
  end

  // The tail is masked combinationally so a flush suppresses a response in the same cycle.
  assign tail_c = flush_mask(stage_q[DEPTH-1], i_flush);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and
// load/store, with data priority, fetch anti-starvation and response routing.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CNT_W-1:0] starve_q;
  logic             force_i;
  mem_tag_t         tail_c;

  // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    force_i = i_req && (starve_q == CNT_W'(STARVE_LIMIT));
    i_gnt   = i_req && (!d_req || force_i);
    d_gnt   = d_req && !i_gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (i_gnt || !i_req) begin
      starve_q <= '0;
    end else if (d_gnt && (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_q <= starve_q + CNT_W'(1);
    end
  end

  // Memory command mux; all fields read as zero when nothing is granted.
  always_comb begin
    mem_req   = i_gnt || d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = BE_W'(0);
    if (i_gnt) begin
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end
  end

  resp_tracker #(
    .DEPTH(MEM_LATENCY)
  ) u_resp_tracker (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_req && !mem_we),
    .push_owner(i_gnt ? OWN_I : OWN_D),
    .i_flush   (i_flush),
    .tail_c    (tail_c)
  );

  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    if (tail_c.valid) begin
      if (tail_c.owner == OWN_I) begin
        i_rvalid = 1'b1;
        i_rdata  = mem_rdata;
      end else begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the core's instruction-fetch port and its load/store port.
- Arbitrates per cycle and issues at most one access per cycle.
- Tracks in-flight reads with a tag pipeline and routes each returning word to its owner.
- Discards fetch responses killed by a branch flush.
- Sits between the core's fetch/data stages and the memory macro; fetch and data stages treat a withheld grant as a stall.

Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits; byte enables are DATA_W/8 bits
- MEM_LATENCY, 1, cycles from an accepted read to memRdata valid (range 1..4)
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch waits before fetch is forced

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- iReq  in  1  fetch read request
- iAddr  in  ADDR_W  fetch address
- iFlush  in  1  discard all in-flight fetch responses
- iGnt  out  1  fetch request accepted this cycle
- iRvalid  out  1  fetch read data valid
- iRdata  out  DATA_W  fetch read data
- dReq  in  1  data request
- dWe  in  1  1 = write, 0 = read
- dAddr  in  ADDR_W  data address
- dWdata  in  DATA_W  write data
- dBe  in  DATA_W/8  write byte enables
- dGnt  out  1  data request accepted this cycle
- dRvalid  out  1  load data valid
- dRdata  out  DATA_W  load data
- memReq  out  1  memory access strobe
- memWe  out  1  memory write enable
- memAddr  out  ADDR_W  memory address
- memWdata  out  DATA_W  memory write data
- memBe  out  DATA_W/8  memory byte enables
- memRdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after the accepted read

Behaviour:
- Grant is combinational from the requests and registered state. At most one of iGnt/dGnt is high in any cycle.
- A requester holds its req and payload stable until granted. Fetch may drop iReq when flushed.
- Priority: data wins by default, because it is the older instruction in the pipeline.
- Starvation counter:
  - increments when dGnt is high while iReq is high and iGnt is low;
  - clears on any iGnt, or on any cycle where iReq is low.
- When the counter equals STARVE_LIMIT and iReq is high, fetch is granted and data waits.
- Memory outputs:
  - memReq = iGnt | dGnt.
  - memAddr, memWe, memWdata and memBe are muxed from the granted port.
  - memWe = 0 for fetch.
  - When idle, memReq = 0 and the other memory outputs are 0.
- Tag pipeline:
  - a MEM_LATENCY-deep shift register of {valid, owner}, advancing every cycle;
  - a stage is loaded valid on a granted read, with owner I or D;
  - writes load an invalid stage and produce no response.
- Response routing: when the tail stage is valid, the owner's Rvalid is asserted for one cycle and its Rdata = memRdata. The non-owner's Rdata is 0.
- Response order per port equals grant order. Back-to-back reads issue every cycle with no bubble.
- iFlush:
  - clears valid on every in-flight owner-I stage, including the tail, in the same cycle, so iRvalid = 0 while iFlush = 1;
  - does not affect owner-D stages;
  - a fetch granted in the same cycle as iFlush is also discarded.
- Reset (asynchronous, any time, including mid-transaction):
  - all tag stages invalid, starvation counter 0;
  - iRvalid = dRvalid = 0 and Rdata = 0;
  - combinational outputs follow from the cleared state;
  - no response is produced for any access accepted before reset.
- Counter width is clog2(STARVE_LIMIT+1) and the counter saturates at STARVE_LIMIT.

Decomposition:
- mem_arb_pkg holds:
  - typedef owner_e {OWN_I, OWN_D};
  - typedef struct mem_tag_t {logic valid; owner_e owner;};
  - constant for the default STARVE_LIMIT.
- One sub-module, resp_tracker: the tag shift register plus flush masking. Ports: Clock, Reset, push/owner, iFlush, tail tag.
- Arbitration and memory muxing stay in the top module.

Test Plan:
- Reset mid-read: iReq at cycle 0, Reset pulsed at cycle 1 (MEM_LATENCY=2) -> iRvalid stays 0; after Reset, iGnt=1 on the next iReq.
- Fetch-only stream: iReq held, addrs 0x0,0x4,0x8 -> iGnt=1 every cycle, iRvalid each cycle starting 1 cycle later (MEM_LATENCY=1), data in address order.
- Simultaneous requests: iReq=dReq=1, dWe=0, dAddr=0x100 -> dGnt=1, iGnt=0, memAddr=0x100; next cycle dRvalid=1 with memRdata.
- Starvation: dReq held high with writes, iReq high, STARVE_LIMIT=4 -> four dGnt, then iGnt=1 on the fifth cycle, then dGnt resumes.
- Flush: fetch reads granted at cycles 0 and 1 (MEM_LATENCY=2), iFlush=1 at cycle 2 -> no iRvalid for either read; a concurrent in-flight load still gives dRvalid=1.
- Write: dWe=1, dBe=4'b0011, dWdata=0xDEADBEEF -> memWe=1, memBe=0011, memWdata matches; no dRvalid follows.
